servo_pwm_multi: RTL and testbench



---
 rtl/servo_pkg.sv | 33 +++
 rtl/servo_pwm_chan.sv | 40 ++++
 rtl/servo_pwm_multi.sv | 79 +++++++
 tb/tb_servo_pwm_multi.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo PWM generator:
// direction encodings and the direction-to-pulse-width decode.
package servo_pkg;

  typedef enum logic [1:0] {
    DIR_STOP = 2'b00,
    DIR_CCW  = 2'b01,
    DIR_CW   = 2'b10,
    DIR_RSVD = 2'b11
  } dir_e;

  // Reserved code falls through to stop; a disabled channel always gets zero.
  function automatic int unsigned decode_width(
    input logic        en,
    input logic [1:0]  dir,
    input logic        stop_pulse,
    input int unsigned t_stop,
    input int unsigned t_ccw,
    input int unsigned t_cw
  );
    int unsigned w;
    w = 32'd0;
    if (en) begin
      case (dir_e'(dir))
        DIR_CCW: w = t_ccw;
        DIR_CW:  w = t_cw;
        default: w = stop_pulse ? t_stop : 32'd0;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo channel: latches its pulse width at the frame wrap and
// drives a registered compare of the shared frame counter.
module servo_pwm_chan
  import servo_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wrap_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] width_i,
  output logic             servo_o
);

  logic [CNT_W-1:0] width_q, width_d;
  logic             servo_q, servo_d;

  // Width only moves at the wrap, so a frame's pulse is never truncated.
  always_comb begin
    width_d = width_q;
    servo_d = (cnt_i < width_q);
    if (wrap_i) begin
      width_d = width_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      width_q <= '0;
      servo_q <= 1'b0;
    end else begin
      width_q <= width_d;
      servo_q <= servo_d;
    end
  end

  assign servo_o = servo_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: one shared tick-driven frame counter,
// per-channel direction decode sampled at the frame wrap.
module servo_pwm_multi #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PERIOD     = 20000,
  parameter int unsigned T_STOP     = 1500,
  parameter int unsigned T_CCW      = 1520,
  parameter int unsigned T_CW       = 1480,
  parameter bit          STOP_PULSE = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic [N_CH-1:0]   en_i,
  input  logic [2*N_CH-1:0] dir_i,
  output logic [N_CH-1:0]   servo_o,
  output logic              frame_start_o
);
  import servo_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  if ((PERIOD < 2) || (T_STOP >= PERIOD) || (T_CCW >= PERIOD) || (T_CW >= PERIOD) ||
      (64'(PERIOD) > (64'd1 << CNT_W))) begin : g_bad_params
    $error("servo_pwm_multi: illegal PERIOD/T_* parameters for CNT_W");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_start_q, frame_start_d;
  logic             wrap_c;

  // Counter advances only on tick; the wrap tick latches all channel widths.
  always_comb begin
    cnt_d         = cnt_q;
    frame_start_d = 1'b0;
    wrap_c        = 1'b0;
    if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d         = '0;
        frame_start_d = 1'b1;
        wrap_c        = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start_o = frame_start_q;

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_chan
    logic [CNT_W-1:0] width_c;

    assign width_c = CNT_W'(decode_width(en_i[g], dir_i[2*g +: 2], STOP_PULSE,
                                         T_STOP, T_CCW, T_CW));

    servo_pwm_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .wrap_i  (wrap_c),
      .cnt_i   (cnt_q),
      .width_i (width_c),
      .servo_o (servo_o[g])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: two instances (stop pulse off/on) against a
// frame-position reference model plus direct pulse/frame length measurements.
module tb_servo_pwm_multi;

  localparam int unsigned N_CH   = 2;
  localparam int unsigned DW     = 2 * N_CH;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PERIOD = 200;
  localparam int unsigned T_STOP = 15;
  localparam int unsigned T_CCW  = 16;
  localparam int unsigned T_CW   = 14;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            tick;
  logic [N_CH-1:0] en;
  logic [DW-1:0]   dir;
  logic [N_CH-1:0] servo0, servo1;
  logic            fs0, fs1;

  int n_vec    = 0;
  int n_err    = 0;
  int tick_div = 1;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .T_STOP(T_STOP),
    .T_CCW(T_CCW), .T_CW(T_CW), .STOP_PULSE(1'b0)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .en_i(en), .dir_i(dir),
    .servo_o(servo0), .frame_start_o(fs0)
  );

  servo_pwm_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .T_STOP(T_STOP),
    .T_CCW(T_CCW), .T_CW(T_CW), .STOP_PULSE(1'b1)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .en_i(en), .dir_i(dir),
    .servo_o(servo1), .frame_start_o(fs1)
  );

  // Tick source: one tick every tick_div clocks, changed away from the active edge.
  initial begin
    int ph;
    ph   = 0;
    tick = 1'b1;
    forever begin
      @(negedge clk);
      if (tick_div <= 1) begin
        tick = 1'b1;
        ph   = 0;
      end else begin
        ph   = (ph + 1) % tick_div;
        tick = (ph == 0);
      end
    end
  end

  function automatic int spec_width(input logic e, input logic [1:0] d, input logic sp);
    if (!e) return 0;
    case (d)
      2'b01:   return int'(T_CCW);
      2'b10:   return int'(T_CW);
      default: return sp ? int'(T_STOP) : 0;
    endcase
  endfunction

  // Reference: position within the frame in ticks, widths chosen at each frame end.
  int              m_pos = 0;
  int              m_w0[N_CH];
  int              m_w1[N_CH];
  logic [N_CH-1:0] e_s0 = '0;
  logic [N_CH-1:0] e_s1 = '0;
  logic            e_fs = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0;
      e_s0  <= '0;
      e_s1  <= '0;
      e_fs  <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) begin
        m_w0[i] <= 0;
        m_w1[i] <= 0;
      end
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        e_s0[i] <= (m_pos < m_w0[i]);
        e_s1[i] <= (m_pos < m_w1[i]);
      end
      e_fs <= 1'b0;
      if (tick) begin
        if (m_pos == int'(PERIOD) - 1) begin
          m_pos <= 0;
          e_fs  <= 1'b1;
          for (int i = 0; i < int'(N_CH); i++) begin
            m_w0[i] <= spec_width(en[i], dir[2*i +: 2], 1'b0);
            m_w1[i] <= spec_width(en[i], dir[2*i +: 2], 1'b1);
          end
        end else begin
          m_pos <= m_pos + 1;
        end
      end
    end
  end

  logic [DW+1:0] obs, expv;
  assign obs  = {servo0, fs0, servo1, fs1};
  assign expv = {e_s0, e_fs, e_s1, e_fs};

  task automatic test_reset();
    rst_n = 1'b0;
    en    = '0;
    dir   = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({servo0, fs0} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_dut0 got %b want 000", {servo0, fs0});
    end
    n_vec++;
    if ({servo1, fs1} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_dut1 got %b want 000", {servo1, fs1});
    end
  endtask

  task automatic test_first_frame();
    int h[4];
    en    = 2'b11;
    dir   = 4'b1001;
    rst_n = 1'b1;
    h = '{default: 0};
    for (int c = 0; c < int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL first_frame c=%0d got %b want %b", c, obs, expv);
      end
      h[0] += int'(servo0[0]); h[1] += int'(servo0[1]);
      h[2] += int'(servo1[0]); h[3] += int'(servo1[1]);
    end
    n_vec++;
    if (h[0] + h[1] + h[2] + h[3] !== 0) begin
      n_err++;
      $display("FAIL first_frame_low got %0d high cycles want 0", h[0] + h[1] + h[2] + h[3]);
    end
    n_vec++;
    if (fs0 !== 1'b1) begin
      n_err++;
      $display("FAIL frame_start_at_wrap got %b want 1", fs0);
    end
    h = '{default: 0};
    for (int c = 0; c < int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL ccw_frame c=%0d got %b want %b", c, obs, expv);
      end
      h[0] += int'(servo0[0]); h[1] += int'(servo0[1]);
      h[2] += int'(servo1[0]); h[3] += int'(servo1[1]);
    end
    n_vec++;
    if (h[0] !== 16 || h[2] !== 16) begin
      n_err++;
      $display("FAIL ccw_width got %0d/%0d want 16/16", h[0], h[2]);
    end
    n_vec++;
    if (h[1] !== 14 || h[3] !== 14) begin
      n_err++;
      $display("FAIL cw_width got %0d/%0d want 14/14", h[1], h[3]);
    end
  endtask

  task automatic test_dir_change();
    int h[4];
    h = '{default: 0};
    for (int c = 0; c < int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL dir_chg_cur c=%0d got %b want %b", c, obs, expv);
      end
      h[0] += int'(servo0[0]);
      if (c == 99) dir[1:0] = 2'b10;
    end
    n_vec++;
    if (h[0] !== 16) begin
      n_err++;
      $display("FAIL dir_chg_current_frame got %0d want 16", h[0]);
    end
    h = '{default: 0};
    for (int c = 0; c < int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL dir_chg_next c=%0d got %b want %b", c, obs, expv);
      end
      h[0] += int'(servo0[0]);
    end
    n_vec++;
    if (h[0] !== 14) begin
      n_err++;
      $display("FAIL dir_chg_next_frame got %0d want 14", h[0]);
    end
  endtask

  task automatic test_stop_pulse();
    int h[4];
    en  = 2'b11;
    dir = 4'b1000;
    for (int c = 0; c < int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL stop_settle c=%0d got %b want %b", c, obs, expv);
      end
    end
    h = '{default: 0};
    for (int c = 0; c < int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL stop_frame c=%0d got %b want %b", c, obs, expv);
      end
      h[0] += int'(servo0[0]); h[1] += int'(servo0[1]);
      h[2] += int'(servo1[0]); h[3] += int'(servo1[1]);
    end
    n_vec++;
    if (h[0] !== 0 || h[2] !== 15) begin
      n_err++;
      $display("FAIL stop_width got %0d/%0d want 0/15", h[0], h[2]);
    end
    n_vec++;
    if (h[1] !== 14 || h[3] !== 14) begin
      n_err++;
      $display("FAIL stop_other_ch got %0d/%0d want 14/14", h[1], h[3]);
    end
  endtask

  task automatic test_en_drop();
    int h[4];
    dir[1:0] = 2'b11;
    h = '{default: 0};
    for (int c = 0; c < int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL en_drop_cur c=%0d got %b want %b", c, obs, expv);
      end
      h[1] += int'(servo0[1]);
      if (c == 5) en[1] = 1'b0;
    end
    n_vec++;
    if (h[1] !== 14) begin
      n_err++;
      $display("FAIL en_drop_pulse_completes got %0d want 14", h[1]);
    end
    h = '{default: 0};
    for (int c = 0; c < int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL en_drop_next c=%0d got %b want %b", c, obs, expv);
      end
      h[0] += int'(servo0[0]); h[1] += int'(servo0[1]);
      h[2] += int'(servo1[0]); h[3] += int'(servo1[1]);
    end
    n_vec++;
    if (h[1] !== 0 || h[3] !== 0) begin
      n_err++;
      $display("FAIL en_drop_next_low got %0d/%0d want 0/0", h[1], h[3]);
    end
    n_vec++;
    if (h[0] !== 0 || h[2] !== 15) begin
      n_err++;
      $display("FAIL rsvd_as_stop got %0d/%0d want 0/15", h[0], h[2]);
    end
  endtask

  task automatic test_reset_mid();
    int h[4];
    en  = 2'b11;
    dir = 4'b1001;
    for (int c = 0; c < int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL rst_mid_settle c=%0d got %b want %b", c, obs, expv);
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL rst_mid_pre c=%0d got %b want %b", c, obs, expv);
      end
    end
    n_vec++;
    if (servo0 !== 2'b11 || servo1 !== 2'b11) begin
      n_err++;
      $display("FAIL rst_mid_pulse_on got %b/%b want 11/11", servo0, servo1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL rst_mid_async_clear got %b want 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    h = '{default: 0};
    for (int c = 0; c < int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL rst_mid_first c=%0d got %b want %b", c, obs, expv);
      end
      h[0] += int'(servo0[0]); h[1] += int'(servo0[1]);
      h[2] += int'(servo1[0]); h[3] += int'(servo1[1]);
    end
    n_vec++;
    if (h[0] + h[1] + h[2] + h[3] !== 0 || fs0 !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_first_frame got %0d highs fs=%b want 0 fs=1",
               h[0] + h[1] + h[2] + h[3], fs0);
    end
    h = '{default: 0};
    for (int c = 0; c < int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL rst_mid_resume c=%0d got %b want %b", c, obs, expv);
      end
      h[0] += int'(servo0[0]); h[1] += int'(servo0[1]);
    end
    n_vec++;
    if (h[0] !== 16 || h[1] !== 14) begin
      n_err++;
      $display("FAIL rst_mid_resume_width got %0d/%0d want 16/14", h[0], h[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4 * int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL random c=%0d got %b want %b", c, obs, expv);
      end
      if ($urandom_range(0, 39) == 0) begin
        en  = N_CH'($urandom);
        dir = DW'($urandom);
      end
    end
  endtask

  task automatic test_tick_div();
    int h[4];
    int k;
    int fs_at;
    en       = 2'b11;
    dir      = 4'b0101;
    tick_div = 3;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (fs0 !== 1'b1 && k < 3 * int'(PERIOD) + 10);
    n_vec++;
    if (fs0 !== 1'b1) begin
      n_err++;
      $display("FAIL tick3_wait_frame got fs=%b after %0d clk want 1", fs0, k);
    end
    h = '{default: 0};
    fs_at = -1;
    for (int c = 0; c < 3 * int'(PERIOD); c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL tick3_frame c=%0d got %b want %b", c, obs, expv);
      end
      h[0] += int'(servo0[0]); h[2] += int'(servo1[0]);
      if (fs0 === 1'b1 && fs_at < 0) fs_at = c;
    end
    n_vec++;
    if (h[0] !== 48 || h[2] !== 48) begin
      n_err++;
      $display("FAIL tick3_width got %0d/%0d want 48/48", h[0], h[2]);
    end
    n_vec++;
    if (fs_at !== 3 * int'(PERIOD) - 1) begin
      n_err++;
      $display("FAIL tick3_frame_len got %0d want %0d", fs_at + 1, 3 * int'(PERIOD));
    end
    tick_div = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = '0;
    dir   = '0;
    test_reset();
    test_first_frame();
    test_dir_change();
    test_stop_pulse();
    test_en_drop();
    test_reset_mid();
    test_random();
    test_tick_div();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
